// File: rtl/vec_math_pkg.sv
// Shared fixed-point vector definitions: opcodes and default widths
// for the vector ALU pipeline and its helpers.
package vec_math_pkg;

    localparam int DEFAULT_W      = 32;
    localparam int DEFAULT_Q_BITS = 10;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_SCALE = 3'd2,
        OP_DOT   = 3'd3,
        OP_CROSS = 3'd4
    } op_e;

    typedef logic signed [DEFAULT_W-1:0] vec3_t [3];

endpackage

// File: rtl/fx_narrow.sv
// Narrows one signed intermediate to W bits, clamping or wrapping,
// and flags whether the value was representable.
module fx_narrow #(
    parameter int IN_W     = 66,
    parameter int W        = 32,
    parameter int SATURATE = 1
) (
    input  logic [IN_W-1:0] d,
    output logic [W-1:0]    q,
    output logic            ovf
);

    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic sign;

    assign sign = d[IN_W-1];
    // In range only if every bit above the result sign matches it.
    assign ovf  = d[IN_W-1:W-1] != {(IN_W-W+1){sign}};

    always_comb begin
        q = d[W-1:0];
        if (SATURATE != 0 && ovf) begin
            q = sign ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage fixed-point vector ALU: add, sub, scale, dot, cross on
// 3-lane signed Q vectors, with valid/ready flow control.
module vec_alu_pipe
    import vec_math_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int Q_BITS   = DEFAULT_Q_BITS,
    parameter int SATURATE = 1,
    parameter int TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [3*W-1:0]   in_x,
    input  logic [3*W-1:0]   in_y,
    input  logic [W-1:0]     in_a,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3*W-1:0]   out_vec,
    output logic [2:0]       out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_op
);

    localparam int PW = 2 * W;
    localparam int IW = 2 * W + 2;

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic signed [W-1:0] xv [3];
    logic signed [W-1:0] yv [3];
    logic signed [W-1:0] av;
    logic signed [W-1:0] ma [6];
    logic signed [W-1:0] mb [6];
    logic signed [PW-1:0] prod [6];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            xv[i] = in_x[i*W +: W];
            yv[i] = in_y[i*W +: W];
        end
        av = in_a;
    end

    // Multipliers 0..2 are shared between the cross terms and the
    // per-lane scale/dot products.
    always_comb begin
        ma[0] = xv[1]; mb[0] = yv[2];
        ma[1] = xv[2]; mb[1] = yv[1];
        ma[2] = xv[2]; mb[2] = yv[0];
        ma[3] = xv[0]; mb[3] = yv[2];
        ma[4] = xv[0]; mb[4] = yv[1];
        ma[5] = xv[1]; mb[5] = yv[0];
        case (op_e'(in_op))
            OP_SCALE: begin
                for (int i = 0; i < 3; i++) begin
                    ma[i] = xv[i];
                    mb[i] = av;
                end
            end
            OP_DOT: begin
                for (int i = 0; i < 3; i++) begin
                    ma[i] = xv[i];
                    mb[i] = yv[i];
                end
            end
            default: ;
        endcase
        for (int i = 0; i < 6; i++) begin
            prod[i] = PW'(ma[i]) * PW'(mb[i]);
        end
    end

    logic                 s1_valid;
    logic [2:0]           s1_op;
    logic [TAG_W-1:0]     s1_tag;
    logic signed [W-1:0]  s1_x [3];
    logic signed [W-1:0]  s1_y [3];
    logic signed [PW-1:0] s1_p [6];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_tag   <= '0;
            for (int i = 0; i < 3; i++) begin
                s1_x[i] <= '0;
                s1_y[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                s1_p[i] <= '0;
            end
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_op    <= in_op;
            s1_tag   <= in_tag;
            for (int i = 0; i < 3; i++) begin
                s1_x[i] <= xv[i];
                s1_y[i] <= yv[i];
            end
            for (int i = 0; i < 6; i++) begin
                s1_p[i] <= prod[i];
            end
        end
    end

    logic signed [IW-1:0] r [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            r[i] = '0;
        end
        case (op_e'(s1_op))
            OP_ADD: begin
                for (int i = 0; i < 3; i++) begin
                    r[i] = IW'(s1_x[i]) + IW'(s1_y[i]);
                end
            end
            OP_SUB: begin
                for (int i = 0; i < 3; i++) begin
                    r[i] = IW'(s1_x[i]) - IW'(s1_y[i]);
                end
            end
            OP_SCALE: begin
                for (int i = 0; i < 3; i++) begin
                    r[i] = IW'(s1_p[i]) >>> Q_BITS;
                end
            end
            OP_DOT: begin
                r[0] = (IW'(s1_p[0]) >>> Q_BITS)
                     + (IW'(s1_p[1]) >>> Q_BITS)
                     + (IW'(s1_p[2]) >>> Q_BITS);
            end
            OP_CROSS: begin
                r[0] = (IW'(s1_p[0]) - IW'(s1_p[1])) >>> Q_BITS;
                r[1] = (IW'(s1_p[2]) - IW'(s1_p[3])) >>> Q_BITS;
                r[2] = (IW'(s1_p[4]) - IW'(s1_p[5])) >>> Q_BITS;
            end
            default: ;
        endcase
    end

    logic [W-1:0] nq [3];
    logic [2:0]   no;

    for (genvar g = 0; g < 3; g++) begin : g_nar
        fx_narrow #(
            .IN_W     (IW),
            .W        (W),
            .SATURATE (SATURATE)
        ) u_nar (
            .d   (r[g]),
            .q   (nq[g]),
            .ovf (no[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_ovf   <= '0;
            out_tag   <= '0;
            out_op    <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            out_vec   <= {nq[2], nq[1], nq[0]};
            out_ovf   <= no;
            out_tag   <= s1_tag;
            out_op    <= s1_op;
        end
    end

endmodule
